// File: rtl/aes_pkg.sv
// Shared AES types, the field polynomial and small GF(2^8) / indexing helpers
// used by the MixColumns datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mc_state_e;

  localparam logic [7:0] AES_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Row r of a column; row 0 is the most significant byte.
  function automatic logic [7:0] get_byte(input col_t c, input int r);
    return c[31-8*r -: 8];
  endfunction

  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    return s[127-32*int'(c) -: 32];
  endfunction

  function automatic logic [1:0] col_idx(input logic [1:0] base, input int off);
    return base + 2'(off);
  endfunction

endpackage

// File: rtl/mix_columns_unit_if.sv
// Input/output handshake bundle of the MixColumns engine; the engine sits on
// the slave side, the producer/consumer on the master side.
interface mix_columns_unit_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   in_inv;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;
  logic   busy;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/mix_columns_unit_mix_column_word.sv
// Combinational (Inv)MixColumns of a single 32-bit column, built from chained
// xtime stages rather than constant multiplier tables.
module mix_column_word
  import aes_pkg::*;
#(
  parameter bit INVERSE_EN = 1'b1
) (
  input  col_t col_in,
  input  logic inv,
  output col_t col_out
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  col_t       fwd_col;

  // Forward row r: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], with 3a = xtime(a)^a.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r]  = get_byte(col_in, r);
      x2[r] = xtime(a[r]);
    end
    fwd_col = '0;
    for (int r = 0; r < 4; r++) begin
      fwd_col[31-8*r -: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4]
                           ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
  end

  if (INVERSE_EN) begin : g_inv
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    col_t       inv_col;

    always_comb begin
      for (int r = 0; r < 4; r++) begin
        x4[r]  = xtime(x2[r]);
        x8[r]  = xtime(x4[r]);
        m09[r] = x8[r] ^ a[r];
        m0b[r] = x8[r] ^ x2[r] ^ a[r];
        m0d[r] = x8[r] ^ x4[r] ^ a[r];
        m0e[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      inv_col = '0;
      for (int r = 0; r < 4; r++) begin
        inv_col[31-8*r -: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
      end
    end

    assign col_out = inv ? inv_col : fwd_col;
  end else begin : g_fwd_only
    logic unused_inv;
    assign unused_inv = inv;
    assign col_out    = fwd_col;
  end

endmodule

// File: rtl/mix_columns_unit.sv
// Sequential AES MixColumns/InvMixColumns engine: latches a full state, runs
// COLS_PER_CYCLE columns per cycle through shared column units, then holds the result.
module mix_columns_unit
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INVERSE_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mix_columns_unit_if.slave  bus
);

  mc_state_e  state_q, state_d;
  state_t     work_q;
  state_t     res_q;
  logic [1:0] col_cnt_q;
  logic       mode_q;
  logic       last_step;
  col_t       col_res [COLS_PER_CYCLE];

  assign last_step = (int'(col_cnt_q) + COLS_PER_CYCLE) == 4;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    col_t sel;
    assign sel = get_col(work_q, col_idx(col_cnt_q, g));
    mix_column_word #(.INVERSE_EN(INVERSE_EN)) u_word (
      .col_in  (sel),
      .inv     (mode_q),
      .col_out (col_res[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_BUSY;
      ST_BUSY: if (last_step)     state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // The mode bit is captured with the state so later in_inv changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q    <= '0;
      res_q     <= '0;
      col_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else if (state_q == ST_IDLE && bus.in_valid) begin
      work_q    <= bus.in_state;
      mode_q    <= INVERSE_EN ? bus.in_inv : 1'b0;
      col_cnt_q <= '0;
    end else if (state_q == ST_BUSY) begin
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
        res_q[127-32*int'(col_idx(col_cnt_q, i)) -: 32] <= col_res[i];
      end
      col_cnt_q <= col_cnt_q + 2'(COLS_PER_CYCLE);
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_state = res_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mix_columns_unit.sv
// Scoreboard bench for mix_columns_unit: four instances (N=1/2/4 with inverse,
// N=2 forward-only) checked against a multiply-based GF(2^8) reference model.
module tb_mix_columns_unit;
  import aes_pkg::*;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic [NDUT-1:0] in_valid_v;
  logic [NDUT-1:0] in_inv_v;
  logic [NDUT-1:0] out_ready_v;
  logic [NDUT-1:0] in_ready_v;
  logic [NDUT-1:0] out_valid_v;
  logic [NDUT-1:0] busy_v;
  state_t          in_state_a  [NDUT];
  state_t          out_state_a [NDUT];

  int checks   = 0;
  int failures = 0;

  state_t          sb_q [NDUT][$];
  int              hs_cyc [NDUT];
  logic [NDUT-1:0] ov_prev = '0;
  state_t          mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar d = 0; d < NDUT; d++) begin : g_dut
    mix_columns_unit_if bus ();
    assign bus.in_valid   = in_valid_v[d];
    assign bus.in_state   = in_state_a[d];
    assign bus.in_inv     = in_inv_v[d];
    assign bus.out_ready  = out_ready_v[d];
    assign in_ready_v[d]  = bus.in_ready;
    assign out_valid_v[d] = bus.out_valid;
    assign out_state_a[d] = bus.out_state;
    assign busy_v[d]      = bus.busy;

    mix_columns_unit #(
      .COLS_PER_CYCLE (d == 0 ? 1 : (d == 2 ? 4 : 2)),
      .INVERSE_EN     (d != 3)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int exp_lat(input int d);
    case (d)
      0:       return 5;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic state_t mix_ref(input state_t s, input bit inv);
    logic [7:0] k [4];
    logic [7:0] acc;
    state_t     o;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(k[j], s[127-8*(4*c+(r+j)%4) -: 8]);
        end
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one state on instance d; the scrambled in_inv afterwards must not matter.
  task automatic applyStimulus(input int d, input state_t st, input logic inv,
                               input state_t exp, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready_v[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_v[d]) begin
      checkOutput($sformatf("in_ready_timeout%0d", d), 0, 1);
      return;
    end
    in_state_a[d] = st;
    in_inv_v[d]   = inv;
    in_valid_v[d] = 1'b1;
    hs_cyc[d]     = cyc;
    if (push) sb_q[d].push_back(exp);
    @(posedge clk);
    #1;
    in_valid_v[d] = 1'b0;
    in_inv_v[d]   = ~inv;
    in_state_a[d] = {4{$urandom}};
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (n < 300 && ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()
                        + sb_q[3].size()) != 0 || busy_v != '0)) begin
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < NDUT; d++) checkOutput($sformatf("drain%0d", d), sb_q[d].size(), 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!rst && out_valid_v[d] && !ov_prev[d])
        checkOutput($sformatf("latency%0d", d), 128'(cyc - hs_cyc[d]), 128'(exp_lat(d)));
      if (!rst && out_valid_v[d] && out_ready_v[d]) begin
        if (sb_q[d].size() == 0) begin
          checkOutput($sformatf("unexpected_out%0d", d), 1, 0);
        end else begin
          mon_exp = sb_q[d].pop_front();
          checkOutput($sformatf("data%0d", d), out_state_a[d], mon_exp);
        end
      end
      ov_prev[d] = out_valid_v[d];
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    state_t vec_in, vec_out, appb_in, appb_out, s, f;
    int     d, n;
    bit     inv;

    vec_in   = 128'hdb135345_f20a225c_01010101_2d26314c;
    vec_out  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    appb_in  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    appb_out = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    rst         = 1'b1;
    in_valid_v  = '0;
    in_inv_v    = '0;
    out_ready_v = '1;
    for (int i = 0; i < NDUT; i++) in_state_a[i] = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("rst_in_ready%0d", i), in_ready_v[i], 0);
      checkOutput($sformatf("rst_out_valid%0d", i), out_valid_v[i], 0);
      checkOutput($sformatf("rst_busy%0d", i), busy_v[i], 0);
      checkOutput($sformatf("rst_out_state%0d", i), out_state_a[i], 0);
    end

    // Reset held together with in_valid: nothing may be accepted.
    in_valid_v[0] = 1'b1;
    in_state_a[0] = vec_in;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst_vs_valid_busy", busy_v[0], 0);
    checkOutput("rst_vs_valid_in_ready", in_ready_v[0], 1);

    applyStimulus(0, vec_in, 1'b0, vec_out, 1'b1);
    applyStimulus(2, appb_in, 1'b0, appb_out, 1'b1);
    applyStimulus(1, vec_out, 1'b1, vec_in, 1'b1);
    applyStimulus(3, vec_out, 1'b1, mix_ref(vec_out, 1'b0), 1'b1);
    waitDrain();

    // Backpressure on the N=1 instance.
    out_ready_v[0] = 1'b0;
    applyStimulus(0, appb_in, 1'b0, appb_out, 1'b1);
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_rise", out_valid_v[0], 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", out_valid_v[0], 1);
      checkOutput("bp_out_state", out_state_a[0], appb_out);
      checkOutput("bp_in_ready", in_ready_v[0], 0);
    end
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_release_in_ready", in_ready_v[0], 1);
    checkOutput("bp_release_out_valid", out_valid_v[0], 0);
    waitDrain();

    // Reset after two busy cycles discards the in-flight state.
    applyStimulus(0, vec_in, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid_v[0], 0);
    checkOutput("midrst_out_state", out_state_a[0], 0);
    checkOutput("midrst_in_ready", in_ready_v[0], 1);
    checkOutput("midrst_busy", busy_v[0], 0);
    applyStimulus(0, {16{8'hc6}}, 1'b0, {16{8'hc6}}, 1'b1);
    waitDrain();

    for (int i = 0; i < 40; i++) begin
      d   = $urandom_range(0, 3);
      s   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      applyStimulus(d, s, inv, mix_ref(s, inv && d != 3), 1'b1);
    end

    // Forward then inverse on the same instance must give back the original.
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 2);
      s = {$urandom, $urandom, $urandom, $urandom};
      f = mix_ref(s, 1'b0);
      applyStimulus(d, s, 1'b0, f, 1'b1);
      applyStimulus(d, f, 1'b1, s, 1'b1);
    end
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
